// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline MEM stage: FSM states, default
// widths and the writeback-stage bubble value.
package mips_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  // A bubble never writes the register file.
  localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/memory_to_writeback_reg.sv
// MEM/WB pipeline register. Loads every cycle; i_Bubble forces an all-zero
// entry so the writeback stage sees a harmless no-op.
module memory_to_writeback_reg
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH    = mips_pkg::DATA_WIDTH,
  parameter int RF_ADDR_WIDTH = mips_pkg::RF_ADDR_WIDTH
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_Bubble,
  input  logic [DATA_WIDTH-1:0]    i_ReadData,
  input  logic [DATA_WIDTH-1:0]    i_ALUOut,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteReg,
  input  wb_ctrl_t                 i_Ctrl,
  output logic [DATA_WIDTH-1:0]    o_ReadDataW,
  output logic [DATA_WIDTH-1:0]    o_ALUOutW,
  output logic [RF_ADDR_WIDTH-1:0] o_WriteRegW,
  output logic                     o_RegWriteW,
  output logic                     o_MemtoRegW
);

  logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
  logic [DATA_WIDTH-1:0]    alu_out_q, alu_out_d;
  logic [RF_ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  wb_ctrl_t                 ctrl_q, ctrl_d;

  always_comb begin
    read_data_d = i_ReadData;
    alu_out_d   = i_ALUOut;
    write_reg_d = i_WriteReg;
    ctrl_d      = i_Ctrl;
    if (i_Bubble) begin
      read_data_d = '0;
      alu_out_d   = '0;
      write_reg_d = '0;
      ctrl_d      = WB_BUBBLE;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      read_data_q <= '0;
      alu_out_q   <= '0;
      write_reg_q <= '0;
      ctrl_q      <= WB_BUBBLE;
    end else begin
      read_data_q <= read_data_d;
      alu_out_q   <= alu_out_d;
      write_reg_q <= write_reg_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign o_ReadDataW = read_data_q;
  assign o_ALUOutW   = alu_out_q;
  assign o_WriteRegW = write_reg_q;
  assign o_RegWriteW = ctrl_q.reg_write;
  assign o_MemtoRegW = ctrl_q.mem_to_reg;

endmodule

// File: rtl/memory_access_stage.sv
// MIPS MEM stage: drives loads/stores over a req/ack bus, stalls upstream while
// an access is pending. Optional MEM_TIMEOUT_EN adds a REQ watchdog and o_MemErr.
//
// Bus handshake: o_MemReq is held high with o_MemWe/o_MemAddr/o_MemWData stable
// from the first REQ cycle until the cycle i_MemAck pulses; that cycle completes
// the access and the next cycle is IDLE. i_MemAck is ignored outside REQ.
module memory_access_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = mips_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = mips_pkg::ADDRESS_WIDTH,
  parameter int RF_ADDR_WIDTH  = mips_pkg::RF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [DATA_WIDTH-1:0]    i_ALUOutM,
  input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic                     i_RegWriteM,
  input  logic                     i_MemtoRegM,
  input  logic                     i_MemWriteM,
  output logic                     o_MemReq,
  output logic                     o_MemWe,
  output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
  output logic [DATA_WIDTH-1:0]    o_MemWData,
  input  logic                     i_MemAck,
  input  logic [DATA_WIDTH-1:0]    i_MemRData,
  output logic                     o_StallM,
  output logic [DATA_WIDTH-1:0]    o_ReadDataW,
  output logic [DATA_WIDTH-1:0]    o_ALUOutW,
  output logic [RF_ADDR_WIDTH-1:0] o_WriteRegW,
  output logic                     o_RegWriteW,
  output logic                     o_MemtoRegW,
  output logic                     o_MemErr,
  output state_e                   o_DbgState
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    alu_q, alu_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [RF_ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic                     regwrite_q, regwrite_d;
  logic                     store_q, store_d;

  logic                     mem_op;
  logic                     in_req;
  logic                     timeout_hit;
  logic [ADDRESS_WIDTH-1:0] addr_w;

  logic                     wb_bubble;
  logic [DATA_WIDTH-1:0]    wb_rdata;
  logic [DATA_WIDTH-1:0]    wb_alu;
  logic [RF_ADDR_WIDTH-1:0] wb_wreg;
  wb_ctrl_t                 wb_ctrl;

  assign mem_op = i_MemtoRegM | i_MemWriteM;
  assign in_req = (state_q == REQ);

  // Bus address is the low bits of the latched ALU result, zero-extended
  // when the bus is wider than the datapath.
  if (ADDRESS_WIDTH <= DATA_WIDTH) begin : g_addr_trunc
    assign addr_w = alu_q[ADDRESS_WIDTH-1:0];
  end else begin : g_addr_zext
    assign addr_w = {{(ADDRESS_WIDTH-DATA_WIDTH){1'b0}}, alu_q};
  end

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_hit = in_req & ~i_MemAck & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_MemErr    = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^CNT_W;
  assign timeout_hit    = 1'b0;
  assign o_MemErr       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    alu_d      = alu_q;
    wdata_d    = wdata_q;
    wreg_d     = wreg_q;
    regwrite_d = regwrite_q;
    store_d    = store_q;
    wb_bubble  = 1'b1;
    wb_rdata   = '0;
    wb_alu     = '0;
    wb_wreg    = '0;
    wb_ctrl    = WB_BUBBLE;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          wb_bubble = 1'b0;
          wb_alu    = i_ALUOutM;
          wb_wreg   = i_WriteRegM;
          wb_ctrl   = '{reg_write: i_RegWriteM, mem_to_reg: 1'b0};
        end else begin
          alu_d      = i_ALUOutM;
          wdata_d    = i_WriteDataM;
          wreg_d     = i_WriteRegM;
          regwrite_d = i_RegWriteM;
          store_d    = i_MemWriteM;
          state_d    = REQ;
`ifdef MEM_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      REQ: begin
        if (i_MemAck) begin
          wb_bubble = 1'b0;
          wb_rdata  = store_q ? '0 : i_MemRData;
          wb_alu    = alu_q;
          wb_wreg   = wreg_q;
          wb_ctrl   = '{reg_write: regwrite_q, mem_to_reg: ~store_q};
          state_d   = IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
`ifdef MEM_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q    <= IDLE;
      alu_q      <= '0;
      wdata_q    <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      store_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      alu_q      <= alu_d;
      wdata_q    <= wdata_d;
      wreg_q     <= wreg_d;
      regwrite_q <= regwrite_d;
      store_q    <= store_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  // Stall drops in the ack (or abort) cycle so EX/MEM advances on the same
  // edge that the MEM/WB register captures the result.
  assign o_StallM   = (~in_req & mem_op) | (in_req & ~i_MemAck & ~timeout_hit);
  assign o_MemReq   = in_req;
  assign o_MemWe    = in_req & store_q;
  assign o_MemAddr  = in_req ? addr_w : '0;
  assign o_MemWData = in_req ? wdata_q : '0;
  assign o_DbgState = state_q;

  memory_to_writeback_reg #(
    .DATA_WIDTH   (DATA_WIDTH),
    .RF_ADDR_WIDTH(RF_ADDR_WIDTH)
  ) u_mem_wb (
    .i_CLK      (i_CLK),
    .i_RST      (i_RST),
    .i_Bubble   (wb_bubble),
    .i_ReadData (wb_rdata),
    .i_ALUOut   (wb_alu),
    .i_WriteReg (wb_wreg),
    .i_Ctrl     (wb_ctrl),
    .o_ReadDataW(o_ReadDataW),
    .o_ALUOutW  (o_ALUOutW),
    .o_WriteRegW(o_WriteRegW),
    .o_RegWriteW(o_RegWriteW),
    .o_MemtoRegW(o_MemtoRegW)
  );

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed testbench for memory_access_stage; the timeout scenario is built
// only when MEM_TIMEOUT_EN is defined.
module tb_memory_access_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] alu_m;
  logic [31:0] wdata_m;
  logic [4:0]  wreg_m;
  logic        regwrite_m;
  logic        memtoreg_m;
  logic        memwrite_m;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] rdata_w;
  logic [31:0] alu_w;
  logic [4:0]  wreg_w;
  logic        regwrite_w;
  logic        memtoreg_w;
  logic        mem_err;
  state_e      dbg_state;

  int checks;
  int failures;

  memory_access_stage #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .RF_ADDR_WIDTH (5),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_ALUOutM   (alu_m),
    .i_WriteDataM(wdata_m),
    .i_WriteRegM (wreg_m),
    .i_RegWriteM (regwrite_m),
    .i_MemtoRegM (memtoreg_m),
    .i_MemWriteM (memwrite_m),
    .o_MemReq    (mem_req),
    .o_MemWe     (mem_we),
    .o_MemAddr   (mem_addr),
    .o_MemWData  (mem_wdata),
    .i_MemAck    (mem_ack),
    .i_MemRData  (mem_rdata),
    .o_StallM    (stall),
    .o_ReadDataW (rdata_w),
    .o_ALUOutW   (alu_w),
    .o_WriteRegW (wreg_w),
    .o_RegWriteW (regwrite_w),
    .o_MemtoRegW (memtoreg_w),
    .o_MemErr    (mem_err),
    .o_DbgState  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers: inputs change #1 after the rising edge, outputs sampled there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop(input logic [31:0] alu, input logic [4:0] wreg, input logic rw);
    alu_m      = alu;
    wdata_m    = 32'h0;
    wreg_m     = wreg;
    regwrite_m = rw;
    memtoreg_m = 1'b0;
    memwrite_m = 1'b0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [4:0] wreg);
    alu_m      = addr;
    wdata_m    = 32'h0;
    wreg_m     = wreg;
    regwrite_m = 1'b1;
    memtoreg_m = 1'b1;
    memwrite_m = 1'b0;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [31:0] data);
    alu_m      = addr;
    wdata_m    = data;
    wreg_m     = 5'd3;
    regwrite_m = 1'b0;
    memtoreg_m = 1'b0;
    memwrite_m = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_nop(32'h0, 5'd0, 1'b0);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    cyc();
    cyc();
    checks++;
    if ({rdata_w, alu_w, wreg_w, regwrite_w, memtoreg_w} !== 71'h0) begin
      failures++;
      $display("FAIL reset_w_regs: got rdata=%h alu=%h wreg=%0d rw=%b m2r=%b, want all 0",
               rdata_w, alu_w, wreg_w, regwrite_w, memtoreg_w);
    end
    checks++;
    if ({mem_req, mem_we, stall, mem_err} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus: got req=%b we=%b stall=%b err=%b addr=%h wdata=%h, want 0",
               mem_req, mem_we, stall, mem_err, mem_addr, mem_wdata);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d want IDLE", dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    drive_nop(32'h1234, 5'd5, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL pass_stall_req: got stall=%b req=%b want 0 0", stall, mem_req);
    end
    cyc();
    checks++;
    if (alu_w !== 32'h1234 || wreg_w !== 5'd5 || regwrite_w !== 1'b1 ||
        memtoreg_w !== 1'b0 || rdata_w !== 32'h0) begin
      failures++;
      $display("FAIL pass_w: got alu=%h wreg=%0d rw=%b m2r=%b rdata=%h want 1234 5 1 0 0",
               alu_w, wreg_w, regwrite_w, memtoreg_w, rdata_w);
    end
  endtask

  task automatic test_load();
    drive_load(32'h40, 5'd7);
    #1;
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL load_detect: got stall=%b req=%b want 1 0", stall, mem_req);
    end
    cyc();
    checks++;
    if (dbg_state !== REQ || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40 ||
        regwrite_w !== 1'b0 || memtoreg_w !== 1'b0) begin
      failures++;
      $display("FAIL load_req: got st=%0d req=%b we=%b addr=%h rw=%b m2r=%b want REQ 1 0 40 0 0",
               dbg_state, mem_req, mem_we, mem_addr, regwrite_w, memtoreg_w);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL load_ack_stall: got %b want 0", stall);
    end
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    drive_nop(32'h0, 5'd0, 1'b0);
    #1;
    checks++;
    if (rdata_w !== 32'hDEADBEEF || memtoreg_w !== 1'b1 || regwrite_w !== 1'b1 ||
        wreg_w !== 5'd7 || alu_w !== 32'h40) begin
      failures++;
      $display("FAIL load_w: got rdata=%h m2r=%b rw=%b wreg=%0d alu=%h want deadbeef 1 1 7 40",
               rdata_w, memtoreg_w, regwrite_w, wreg_w, alu_w);
    end
    checks++;
    if (dbg_state !== IDLE || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL load_idle: got st=%0d req=%b addr=%h want IDLE 0 0", dbg_state, mem_req, mem_addr);
    end
  endtask

  task automatic test_store();
    int stall_cycles;
    int bad_bus;
    int bad_bubble;
    stall_cycles = 0;
    bad_bus      = 0;
    bad_bubble   = 0;
    drive_store(32'h80, 32'hA5A5A5A5);
    #1;
    if (stall === 1'b1) stall_cycles++;
    cyc();
    for (int i = 0; i < 3; i++) begin
      if (stall === 1'b1) stall_cycles++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'hA5A5A5A5)
        bad_bus++;
      if (regwrite_w !== 1'b0 || alu_w !== 32'h0) bad_bubble++;
      cyc();
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h11111111;
    #1;
    if (stall === 1'b1) stall_cycles++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'hA5A5A5A5)
      bad_bus++;
    checks++;
    if (bad_bus != 0) begin
      failures++;
      $display("FAIL store_bus_stable: %0d of 4 REQ cycles had wrong req/we/addr/wdata, want 0", bad_bus);
    end
    checks++;
    if (bad_bubble != 0) begin
      failures++;
      $display("FAIL store_bubble: %0d wait cycles without bubble in W, want 0", bad_bubble);
    end
    checks++;
    if (stall_cycles != 4) begin
      failures++;
      $display("FAIL store_stall_count: got %0d want 4", stall_cycles);
    end
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    drive_nop(32'h0, 5'd0, 1'b0);
    #1;
    checks++;
    if (regwrite_w !== 1'b0 || memtoreg_w !== 1'b0 || rdata_w !== 32'h0 ||
        alu_w !== 32'h80 || wreg_w !== 5'd3) begin
      failures++;
      $display("FAIL store_w: got rw=%b m2r=%b rdata=%h alu=%h wreg=%0d want 0 0 0 80 3",
               regwrite_w, memtoreg_w, rdata_w, alu_w, wreg_w);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL store_idle_bus: got req=%b we=%b wdata=%h want 0 0 0", mem_req, mem_we, mem_wdata);
    end
  endtask

  task automatic test_reset_in_req();
    drive_load(32'h100, 5'd9);
    cyc();
    cyc();
    checks++;
    if (dbg_state !== REQ || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rstreq_setup: got st=%0d req=%b want REQ 1", dbg_state, mem_req);
    end
    rst = 1'b1;
    cyc();
    checks++;
    if (dbg_state !== IDLE || mem_req !== 1'b0 || mem_addr !== 32'h0 ||
        {rdata_w, alu_w, wreg_w, regwrite_w, memtoreg_w} !== 71'h0) begin
      failures++;
      $display("FAIL rstreq_clear: got st=%0d req=%b addr=%h alu_w=%h rw=%b want IDLE 0 0 0 0",
               dbg_state, mem_req, mem_addr, alu_w, regwrite_w);
    end
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    drive_nop(32'h0, 5'd0, 1'b0);
    cyc();
    mem_ack = 1'b0;
    checks++;
    if (dbg_state !== IDLE || rdata_w !== 32'h0 || regwrite_w !== 1'b0 || memtoreg_w !== 1'b0) begin
      failures++;
      $display("FAIL rstreq_late_ack: got st=%0d rdata=%h rw=%b m2r=%b want IDLE 0 0 0",
               dbg_state, rdata_w, regwrite_w, memtoreg_w);
    end
  endtask

  task automatic test_spurious_ack();
    drive_nop(32'h55AA, 5'd12, 1'b1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL spur_stall_req: got stall=%b req=%b want 0 0", stall, mem_req);
    end
    cyc();
    mem_ack = 1'b0;
    checks++;
    if (dbg_state !== IDLE || alu_w !== 32'h55AA || wreg_w !== 5'd12 || regwrite_w !== 1'b1 ||
        rdata_w !== 32'h0 || memtoreg_w !== 1'b0) begin
      failures++;
      $display("FAIL spur_w: got st=%0d alu=%h wreg=%0d rw=%b rdata=%h m2r=%b want IDLE 55aa 12 1 0 0",
               dbg_state, alu_w, wreg_w, regwrite_w, rdata_w, memtoreg_w);
    end
  endtask

  task automatic test_back_to_back();
    drive_load(32'h200, 5'd10);
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 32'h00000001;
    cyc();
    mem_ack = 1'b0;
    drive_load(32'h204, 5'd11);
    #1;
    checks++;
    if (dbg_state !== IDLE || stall !== 1'b1 || rdata_w !== 32'h1 || wreg_w !== 5'd10) begin
      failures++;
      $display("FAIL b2b_first: got st=%0d stall=%b rdata=%h wreg=%0d want IDLE 1 1 10",
               dbg_state, stall, rdata_w, wreg_w);
    end
    cyc();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h204 || regwrite_w !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_req: got req=%b addr=%h rw=%b want 1 204 0", mem_req, mem_addr, regwrite_w);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h00000002;
    cyc();
    mem_ack = 1'b0;
    drive_nop(32'h0, 5'd0, 1'b0);
    #1;
    checks++;
    if (rdata_w !== 32'h2 || wreg_w !== 5'd11 || alu_w !== 32'h204 || memtoreg_w !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_w: got rdata=%h wreg=%0d alu=%h m2r=%b want 2 11 204 1",
               rdata_w, wreg_w, alu_w, memtoreg_w);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int bad_wait;
    bad_wait = 0;
    drive_load(32'h300, 5'd13);
    cyc();
    for (int i = 0; i < 3; i++) begin
      if (mem_req !== 1'b1 || stall !== 1'b1 || mem_err !== 1'b0) bad_wait++;
      cyc();
    end
    checks++;
    if (bad_wait != 0) begin
      failures++;
      $display("FAIL tmo_wait: %0d of 3 early REQ cycles wrong, want 0", bad_wait);
    end
    checks++;
    if (mem_req !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL tmo_abort_cycle: got req=%b stall=%b want 1 0", mem_req, stall);
    end
    cyc();
    drive_nop(32'h0, 5'd0, 1'b0);
    #1;
    checks++;
    if (dbg_state !== IDLE || mem_err !== 1'b1 || regwrite_w !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL tmo_after: got st=%0d err=%b rw=%b req=%b want IDLE 1 0 0",
               dbg_state, mem_err, regwrite_w, mem_req);
    end
    cyc();
    cyc();
    checks++;
    if (mem_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_sticky: got err=%b want 1", mem_err);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (mem_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_reset_clear: got err=%b want 0", mem_err);
    end
  endtask
`else
  task automatic test_no_timeout();
    drive_load(32'h300, 5'd13);
    cyc();
    for (int i = 0; i < 70; i++) cyc();
    checks++;
    if (dbg_state !== REQ || stall !== 1'b1 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL notmo_wait: got st=%0d stall=%b err=%b want REQ 1 0", dbg_state, stall, mem_err);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    cyc();
    mem_ack = 1'b0;
    drive_nop(32'h0, 5'd0, 1'b0);
    #1;
    checks++;
    if (rdata_w !== 32'hCAFEF00D || wreg_w !== 5'd13 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL notmo_ack: got rdata=%h wreg=%0d err=%b want cafef00d 13 0", rdata_w, wreg_w, mem_err);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    mem_ack  = 1'b0;
    mem_rdata = 32'h0;
    drive_nop(32'h0, 5'd0, 1'b0);
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_reset_in_req();
    test_spurious_ack();
    test_back_to_back();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
